// File: rtl/param_cache.sv
// param_cache: set-associative write-back cache with tree pseudo-LRU.
// 32-bit CPU word port in front of a line-wide memory port.
module param_cache #(
   parameter int S_OFFSET = 5,
   parameter int S_INDEX  = 3,
   parameter int NUM_WAYS = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [31:0]                  mem_address,
   input  logic                         mem_read,
   input  logic                         mem_write,
   input  logic [3:0]                   mem_byte_enable,
   input  logic [31:0]                  mem_wdata,
   output logic [31:0]                  mem_rdata,
   output logic                         mem_resp,
   output logic                         pmem_read,
   output logic                         pmem_write,
   output logic [31:0]                  pmem_address,
   output logic [8*(2**S_OFFSET)-1:0]   pmem_wdata,
   input  logic [8*(2**S_OFFSET)-1:0]   pmem_rdata,
   input  logic                         pmem_resp
);

   localparam int LINE_W = 8 * (2**S_OFFSET);
   localparam int SETS   = 2**S_INDEX;
   localparam int TAG_W  = 32 - S_OFFSET - S_INDEX;
   localparam int LW     = $clog2(NUM_WAYS);
   localparam int WORD_W = S_OFFSET - 2;

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] CHECK     = 2'd1;
   localparam logic [1:0] WRITEBACK = 2'd2;
   localparam logic [1:0] ALLOCATE  = 2'd3;

   logic [LINE_W-1:0]   data_q  [SETS][NUM_WAYS];
   logic [TAG_W-1:0]    tag_q   [SETS][NUM_WAYS];
   logic [NUM_WAYS-1:0] valid_q [SETS];
   logic [NUM_WAYS-1:0] dirty_q [SETS];
   logic [NUM_WAYS-2:0] plru_q  [SETS];

   logic [1:0]          state_q;
   logic [1:0]          state_d;
   logic [LW-1:0]       victim_q;
   logic [LW-1:0]       victim_d;
   logic                has_inv;

   logic [TAG_W-1:0]    req_tag;
   logic [S_INDEX-1:0]  idx;
   logic [WORD_W-1:0]   word;
   logic                req;
   logic                hit;
   logic [LW-1:0]       hit_way;
   logic [LINE_W-1:0]   hit_line;
   logic [31:0]         hit_word;
   logic [31:0]         merged;
   logic                fill;
   logic                unused;

   assign req_tag = mem_address[31 -: TAG_W];
   assign idx     = mem_address[S_OFFSET +: S_INDEX];
   assign word    = mem_address[2 +: WORD_W];
   assign req     = mem_read | mem_write;
   assign unused  = ^mem_address[1:0];

   // Heap-numbered tree: node n has children 2n and 2n+1, leaves are ways.
   // Each bit points toward the less recently used half.
   function automatic logic [LW-1:0] plru_victim(
      input logic [NUM_WAYS-2:0] bits
   );
      int node;
      int nxt;
      node = 1;
      for (int l = 0; l < LW; l++) begin
         nxt = node;
         for (int n = 1; n < NUM_WAYS; n++)
            if (n == node)
               nxt = 2 * node + (bits[n-1] ? 1 : 0);
         node = nxt;
      end
      return LW'(node - NUM_WAYS);
   endfunction

   function automatic logic [NUM_WAYS-2:0] plru_touch(
      input logic [NUM_WAYS-2:0] bits,
      input logic [LW-1:0]       way
   );
      logic [NUM_WAYS-2:0] r;
      r = bits;
      for (int l = 0; l < LW; l++)
         for (int n = 1; n < NUM_WAYS; n++)
            if (n == (1 << l) + (int'(way) >> (LW - l)))
               r[n-1] = ~way[LW-1-l];
      return r;
   endfunction

   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = 0; w < NUM_WAYS; w++)
         if (!hit && valid_q[idx][w] && tag_q[idx][w] == req_tag) begin
            hit     = 1'b1;
            hit_way = LW'(w);
         end
   end

   always_comb begin
      has_inv  = 1'b0;
      victim_d = plru_victim(plru_q[idx]);
      for (int w = 0; w < NUM_WAYS; w++)
         if (!has_inv && !valid_q[idx][w]) begin
            has_inv  = 1'b1;
            victim_d = LW'(w);
         end
   end

   assign hit_line = data_q[idx][hit_way];
   assign hit_word = hit_line[{word, 5'b0} +: 32];

   always_comb begin
      merged = hit_word;
      for (int b = 0; b < 4; b++)
         if (mem_byte_enable[b])
            merged[8*b +: 8] = mem_wdata[8*b +: 8];
   end

   assign mem_resp     = (state_q == CHECK) && hit;
   assign mem_rdata    = mem_resp ? hit_word : 32'h0;
   assign pmem_write   = (state_q == WRITEBACK);
   assign pmem_read    = (state_q == ALLOCATE);
   assign pmem_wdata   = data_q[idx][victim_q];
   assign pmem_address = pmem_write
      ? {tag_q[idx][victim_q], idx, {S_OFFSET{1'b0}}}
      : {req_tag, idx, {S_OFFSET{1'b0}}};
   assign fill = (state_q == ALLOCATE) && pmem_resp;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:
            if (req)
               state_d = CHECK;
         CHECK:
            if (hit)
               state_d = IDLE;
            else if (valid_q[idx][victim_d] && dirty_q[idx][victim_d])
               state_d = WRITEBACK;
            else
               state_d = ALLOCATE;
         WRITEBACK:
            if (pmem_resp)
               state_d = ALLOCATE;
         ALLOCATE:
            if (pmem_resp)
               state_d = CHECK;
         default:
            state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         victim_q <= '0;
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            plru_q[s]  <= '0;
         end
      end else begin
         state_q <= state_d;
         if (state_q == CHECK && !hit)
            victim_q <= victim_d;
         if (mem_resp) begin
            plru_q[idx] <= plru_touch(plru_q[idx], hit_way);
            if (mem_write)
               dirty_q[idx][hit_way] <= 1'b1;
         end
         if (fill) begin
            valid_q[idx][victim_q] <= 1'b1;
            dirty_q[idx][victim_q] <= 1'b0;
         end
      end
   end

   // Data and tags are never cleared, but a reset cycle blocks every update.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (fill) begin
            data_q[idx][victim_q] <= pmem_rdata;
            tag_q[idx][victim_q]  <= req_tag;
         end else if (mem_resp && mem_write) begin
            data_q[idx][hit_way][{word, 5'b0} +: 32] <= merged;
         end
      end
   end

endmodule

// File: doc/param_cache.md
PARAM_CACHE -- requirements
Module: param_cache

Interface
REQ-001 Parameter S_OFFSET, 5, log2 of line size in bytes; line width = 8*2**S_OFFSET bits (256 at default).
REQ-002 Parameter S_INDEX, 3, log2 of set count; tag width = 32-S_OFFSET-S_INDEX.
REQ-003 Parameter NUM_WAYS, 4, associativity; legal values 2, 4, 8.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 mem_address  input  32  CPU byte address.
REQ-007 mem_read / mem_write  input  1 each  CPU request strobes, held stable until mem_resp.
REQ-008 mem_byte_enable  input  4  byte lanes of mem_wdata to write.
REQ-009 mem_wdata  input  32  CPU write data; mem_rdata  output  32  CPU read data.
REQ-010 mem_resp  output  1  one-cycle CPU completion pulse.
REQ-011 pmem_read / pmem_write  output  1 each  line-memory request strobes.
REQ-012 pmem_address  output  32  line-aligned address, low S_OFFSET bits zero.
REQ-013 pmem_wdata  output  line width  victim line; pmem_rdata  input  line width  fill line; pmem_resp  input  1  line-memory completion.

Function
REQ-014 Organisation: 2**S_INDEX sets by NUM_WAYS ways; per line: valid, dirty, tag, data; per set: NUM_WAYS-1 tree pseudo-LRU bits.
REQ-015 Address split: tag=[31:S_INDEX+S_OFFSET], index=[S_INDEX+S_OFFSET-1:S_OFFSET], word=[S_OFFSET-1:2].
REQ-016 FSM states: IDLE, CHECK, WRITEBACK, ALLOCATE.
REQ-017 IDLE -> CHECK when mem_read or mem_write; otherwise stay.
REQ-018 CHECK with hit (valid way, matching tag):
- assert mem_resp for exactly that cycle; return to IDLE.
- read: drive selected 32-bit word onto mem_rdata.
- write: merge mem_wdata per mem_byte_enable into the word; set dirty on the hit way.
- update PLRU so the hit way becomes most recent.
REQ-019 If mem_read and mem_write are both asserted, the request is a write.
REQ-020 Hit latency: 2 cycles from request assertion to mem_resp.
REQ-021 CHECK with miss: choose victim = lowest-index invalid way, else PLRU-indicated way; victim is registered until fill completes.
REQ-022 Miss with valid and dirty victim -> WRITEBACK; otherwise -> ALLOCATE.
REQ-023 WRITEBACK: pmem_write=1; pmem_address={victim tag, index, 0}; pmem_wdata=victim line; stay until pmem_resp, then -> ALLOCATE.
REQ-024 ALLOCATE: pmem_read=1; pmem_address={request tag, index, 0}; on pmem_resp write pmem_rdata into victim, set valid, clear dirty, load tag, then -> CHECK.
REQ-025 The retried CHECK hits and completes per REQ-018; PLRU is updated only on hits.
REQ-026 pmem_read and pmem_write are never asserted together.
REQ-027 mem_resp is never asserted outside CHECK.
REQ-028 pmem_resp outside WRITEBACK/ALLOCATE is ignored.

Reset
REQ-029 rst high at a clock edge:
- state=IDLE; all valid, dirty and PLRU bits cleared.
- mem_resp=0, pmem_read=0, pmem_write=0 from the next cycle.
- data and tag arrays are not cleared.
REQ-030 Reset mid-WRITEBACK or mid-ALLOCATE aborts the transfer; no array is updated by a pmem_resp coincident with rst.

Verification
REQ-031 After reset, read 0x00000104 -> ALLOCATE at pmem_address 0x00000100; fill word1=0xDEADBEEF -> mem_resp with mem_rdata=0xDEADBEEF; no pmem_write.
REQ-032 Write 0x00000104 data 0x11223344 with byte_enable 0b0011, then read it -> mem_rdata=0xDEAD3344; hit mem_resp 2 cycles after request; no pmem traffic.
REQ-033 Fill set 0 with NUM_WAYS=4 via tags 1..4, touch tag 1, miss tag 5 -> PLRU victim is not tag 1's way; victim is clean, so ALLOCATE only.
REQ-034 Dirty victim eviction -> pmem_write first with the old line address and the written data; after pmem_resp, pmem_read at the new address; pmem_read and pmem_write never overlap.
REQ-035 Assert rst during ALLOCATE while pmem_resp=1 -> next cycle pmem_read=0 and state IDLE; re-read of the same address misses.
REQ-036 Sweep NUM_WAYS in {2,8} and S_INDEX in {3,4} with random traffic against a reference memory model -> mem_rdata always matches the model.
